// File: rtl/pipe_hazard_gen.sv
// Pipeline hazard arbiter: merges fetch/load-use/branch/multicycle/dmem/trap
// requests into one stall/clear pattern for every pipeline register pair.
module pipe_hazard_gen #(
  parameter int MC_LAT    = 4,
  parameter int FLUSH_LEN = 2,
  parameter int CNT_W     = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic IMEM_WAIT,
  input  logic LD_USE_HZD,
  input  logic BR_TAKEN,
  input  logic MC_START,
  input  logic DMEM_WAIT,
  input  logic TRAP_REQ,
  output logic IF_STALL_D,
  output logic ID1_STALL_D,
  output logic ID2_STALL_D,
  output logic ID1_CLEAR_D,
  output logic ID2_CLEAR_D,
  output logic EX1_STALL_D,
  output logic EX2_STALL_D,
  output logic EX1_CLEAR_D,
  output logic EX2_CLEAR_D,
  output logic ME1_STALL_D,
  output logic ME2_STALL_D,
  output logic ME1_CLEAR_D,
  output logic ME2_CLEAR_D,
  output logic WB1_STALL_D,
  output logic WB2_STALL_D,
  output logic WB1_CLEAR_D,
  output logic WB2_CLEAR_D,
  output logic HZD_BUSY
);

  typedef enum logic [1:0] {
    RUN,
    MC_BUSY,
    FLUSH
  } state_t;

  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LAT - 2);
  localparam logic [CNT_W-1:0] FL_LOAD = CNT_W'(FLUSH_LEN - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_done_q, mc_done_d;

  logic mc_hold;
  logic s_if, s_id, s_ex, s_me;
  logic c_id, c_ex, c_me, c_wb;

  // mc_done blocks a still-asserted MC_START from starting a second op
  assign mc_hold = (state_q == MC_BUSY) ||
                   ((state_q == RUN) && MC_START && !mc_done_q);

  always_comb begin
    s_if = 1'b0;
    s_id = 1'b0;
    s_ex = 1'b0;
    s_me = 1'b0;
    c_id = 1'b0;
    c_ex = 1'b0;
    c_me = 1'b0;
    c_wb = 1'b0;
    if (RST) begin
      s_if = 1'b0;
    end else if (TRAP_REQ) begin
      c_id = 1'b1;
      c_ex = 1'b1;
      c_me = 1'b1;
      c_wb = 1'b1;
    end else if (state_q == FLUSH) begin
      s_if = 1'b1;
      c_id = 1'b1;
    end else if (DMEM_WAIT) begin
      s_if = 1'b1;
      s_id = 1'b1;
      s_ex = 1'b1;
      s_me = 1'b1;
      c_wb = 1'b1;
    end else if (mc_hold) begin
      s_if = 1'b1;
      s_id = 1'b1;
      s_ex = 1'b1;
      c_me = 1'b1;
    end else if (BR_TAKEN) begin
      c_id = 1'b1;
      c_ex = 1'b1;
    end else if (LD_USE_HZD) begin
      s_if = 1'b1;
      s_id = 1'b1;
      c_ex = 1'b1;
    end else if (IMEM_WAIT) begin
      s_if = 1'b1;
      c_id = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mc_done_d = mc_done_q;
    if (TRAP_REQ) begin
      state_d   = FLUSH;
      cnt_d     = FL_LOAD;
      mc_done_d = 1'b0;
    end else begin
      case (state_q)
        FLUSH: begin
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - ONE;
        end
        MC_BUSY: begin
          // counts through dmem stalls; RUN then holds EX until release
          if (cnt_q == '0) begin
            state_d   = RUN;
            mc_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        RUN: begin
          if (MC_START && !mc_done_q) begin
            state_d = MC_BUSY;
            cnt_d   = MC_LOAD;
          end else if (!s_ex) begin
            mc_done_d = 1'b0;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mc_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mc_done_q <= mc_done_d;
    end
  end

  assign IF_STALL_D  = s_if;
  assign ID1_STALL_D = s_id;
  assign ID2_STALL_D = s_id;
  assign ID1_CLEAR_D = c_id;
  assign ID2_CLEAR_D = c_id;
  assign EX1_STALL_D = s_ex;
  assign EX2_STALL_D = s_ex;
  assign EX1_CLEAR_D = c_ex;
  assign EX2_CLEAR_D = c_ex;
  assign ME1_STALL_D = s_me;
  assign ME2_STALL_D = s_me;
  assign ME1_CLEAR_D = c_me;
  assign ME2_CLEAR_D = c_me;
  assign WB1_STALL_D = 1'b0;
  assign WB2_STALL_D = 1'b0;
  assign WB1_CLEAR_D = c_wb;
  assign WB2_CLEAR_D = c_wb;
  assign HZD_BUSY    = !RST && (state_q != RUN);

endmodule

// File: tb/tb_pipe_hazard_gen.sv
// Directed bench for pipe_hazard_gen: per-cycle stimulus tables with
// hand-derived stall/clear patterns, compared on the falling edge.
module tb_pipe_hazard_gen;

  logic CLK;
  logic RST;
  logic IMEM_WAIT, LD_USE_HZD, BR_TAKEN, MC_START, DMEM_WAIT, TRAP_REQ;
  logic IF_STALL_D;
  logic ID1_STALL_D, ID2_STALL_D, ID1_CLEAR_D, ID2_CLEAR_D;
  logic EX1_STALL_D, EX2_STALL_D, EX1_CLEAR_D, EX2_CLEAR_D;
  logic ME1_STALL_D, ME2_STALL_D, ME1_CLEAR_D, ME2_CLEAR_D;
  logic WB1_STALL_D, WB2_STALL_D, WB1_CLEAR_D, WB2_CLEAR_D;
  logic HZD_BUSY;
  logic [17:0] obs;

  int n_chk = 0;
  int n_fail = 0;

  pipe_hazard_gen #(
    .MC_LAT(4),
    .FLUSH_LEN(2),
    .CNT_W(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .IMEM_WAIT(IMEM_WAIT),
    .LD_USE_HZD(LD_USE_HZD),
    .BR_TAKEN(BR_TAKEN),
    .MC_START(MC_START),
    .DMEM_WAIT(DMEM_WAIT),
    .TRAP_REQ(TRAP_REQ),
    .IF_STALL_D(IF_STALL_D),
    .ID1_STALL_D(ID1_STALL_D),
    .ID2_STALL_D(ID2_STALL_D),
    .ID1_CLEAR_D(ID1_CLEAR_D),
    .ID2_CLEAR_D(ID2_CLEAR_D),
    .EX1_STALL_D(EX1_STALL_D),
    .EX2_STALL_D(EX2_STALL_D),
    .EX1_CLEAR_D(EX1_CLEAR_D),
    .EX2_CLEAR_D(EX2_CLEAR_D),
    .ME1_STALL_D(ME1_STALL_D),
    .ME2_STALL_D(ME2_STALL_D),
    .ME1_CLEAR_D(ME1_CLEAR_D),
    .ME2_CLEAR_D(ME2_CLEAR_D),
    .WB1_STALL_D(WB1_STALL_D),
    .WB2_STALL_D(WB2_STALL_D),
    .WB1_CLEAR_D(WB1_CLEAR_D),
    .WB2_CLEAR_D(WB2_CLEAR_D),
    .HZD_BUSY(HZD_BUSY)
  );

  assign obs = {IF_STALL_D,
                ID1_STALL_D, ID2_STALL_D, ID1_CLEAR_D, ID2_CLEAR_D,
                EX1_STALL_D, EX2_STALL_D, EX1_CLEAR_D, EX2_CLEAR_D,
                ME1_STALL_D, ME2_STALL_D, ME1_CLEAR_D, ME2_CLEAR_D,
                WB1_STALL_D, WB2_STALL_D, WB1_CLEAR_D, WB2_CLEAR_D,
                HZD_BUSY};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [17:0] pat(
    input logic ifs, ids, idc, exs, exc, mes, mec, wbc, bsy);
    return {ifs, ids, ids, idc, idc, exs, exs, exc, exc,
            mes, mes, mec, mec, 1'b0, 1'b0, wbc, wbc, bsy};
  endfunction

  localparam logic [17:0] P0      = '0;
  localparam logic [17:0] B       = 18'd1;
  localparam logic [17:0] P_TRAP  = pat(0, 0, 1, 0, 1, 0, 1, 1, 0);
  localparam logic [17:0] P_FLUSH = pat(1, 0, 1, 0, 0, 0, 0, 0, 0);
  localparam logic [17:0] P_DMEM  = pat(1, 1, 0, 1, 0, 1, 0, 1, 0);
  localparam logic [17:0] P_MC    = pat(1, 1, 0, 1, 0, 0, 1, 0, 0);
  localparam logic [17:0] P_BR    = pat(0, 0, 1, 0, 1, 0, 0, 0, 0);
  localparam logic [17:0] P_LD    = pat(1, 1, 0, 0, 1, 0, 0, 0, 0);
  localparam logic [17:0] P_IM    = pat(1, 0, 1, 0, 0, 0, 0, 0, 0);

  // stimulus bits: {rst, imem, ld, br, mc, dm, tr}
  localparam logic [6:0] S0  = 7'b0000000;
  localparam logic [6:0] RS  = 7'b1000000;
  localparam logic [6:0] IM  = 7'b0100000;
  localparam logic [6:0] LD  = 7'b0010000;
  localparam logic [6:0] BR  = 7'b0001000;
  localparam logic [6:0] MC  = 7'b0000100;
  localparam logic [6:0] DM  = 7'b0000010;
  localparam logic [6:0] TR  = 7'b0000001;

  task automatic apply(input logic [6:0] v);
    {RST, IMEM_WAIT, LD_USE_HZD, BR_TAKEN,
     MC_START, DMEM_WAIT, TRAP_REQ} = v;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] st [3];
    st = '{RS | IM | TR, RS | MC | DM, RS | LD | BR};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      @(negedge CLK);
      n_chk++;
      if (obs !== P0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs, P0);
      end
      next_cycle();
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      apply(S0);
      @(negedge CLK);
      n_chk++;
      if (obs !== P0) begin
        n_fail++;
        $display("FAIL idle[%0d]: got %b want %b", i, obs, P0);
      end
      next_cycle();
    end
  endtask

  task automatic test_ld_use();
    logic [6:0]  st [8];
    logic [17:0] ex [8];
    st = '{LD, S0, LD | BR, S0, IM | LD, IM, IM | BR, S0};
    ex = '{P_LD, P0, P_BR, P0, P_LD, P_IM, P_BR, P0};
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      @(negedge CLK);
      n_chk++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL ld_use[%0d]: got %b want %b", i, obs, ex[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_dmem();
    logic [6:0]  st [3];
    logic [17:0] ex [3];
    st = '{DM, DM | IM | LD | BR, S0};
    ex = '{P_DMEM, P_DMEM, P0};
    for (int i = 0; i < 3; i++) begin
      apply(st[i]);
      @(negedge CLK);
      n_chk++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL dmem[%0d]: got %b want %b", i, obs, ex[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_multicycle();
    logic [6:0]  st [12];
    logic [17:0] ex [12];
    st = '{MC, MC, MC, MC, MC, S0,
           MC, MC, MC | BR, MC | BR, MC | BR, S0};
    ex = '{P_MC, P_MC | B, P_MC | B, P_MC | B, P0, P0,
           P_MC, P_MC | B, P_MC | B, P_MC | B, P_BR, P0};
    for (int i = 0; i < 12; i++) begin
      apply(st[i]);
      @(negedge CLK);
      n_chk++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL multicycle[%0d]: got %b want %b", i, obs, ex[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_mc_dmem();
    logic [6:0]  st [8];
    logic [17:0] ex [8];
    st = '{MC, MC, MC | DM, MC | DM, MC | DM, MC | DM, MC, S0};
    ex = '{P_MC, P_MC | B, P_DMEM | B, P_DMEM | B,
           P_DMEM, P_DMEM, P0, P0};
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      @(negedge CLK);
      n_chk++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL mc_dmem[%0d]: got %b want %b", i, obs, ex[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_trap();
    logic [6:0]  st [10];
    logic [17:0] ex [10];
    st = '{MC, MC | TR, DM | BR | LD, DM, S0,
           TR, TR, S0, S0, S0};
    ex = '{P_MC, P_TRAP | B, P_FLUSH | B, P_FLUSH | B, P0,
           P_TRAP, P_TRAP | B, P_FLUSH | B, P_FLUSH | B, P0};
    for (int i = 0; i < 10; i++) begin
      apply(st[i]);
      @(negedge CLK);
      n_chk++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL trap[%0d]: got %b want %b", i, obs, ex[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0]  st [12];
    logic [17:0] ex [12];
    st = '{TR, RS | DM, IM, S0,
           MC, MC | RS, MC, MC, MC, MC, MC, S0};
    ex = '{P_TRAP, P0, P_IM, P0,
           P_MC, P0, P_MC, P_MC | B, P_MC | B, P_MC | B, P0, P0};
    for (int i = 0; i < 12; i++) begin
      apply(st[i]);
      @(negedge CLK);
      n_chk++;
      if (obs !== ex[i]) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: got %b want %b", i, obs, ex[i]);
      end
      next_cycle();
    end
  endtask

  initial begin
    apply(RS);
    test_reset();
    test_idle();
    test_ld_use();
    test_dmem();
    test_multicycle();
    test_mc_dmem();
    test_trap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_gen.md
Name: pipe_hazard_gen

Overview:
Generates the per-stage STALL/CLEAR request vector (IF, ID1/2, EX1/2, ME1/2, WB1/2) that the pipeline controller forwards to every pipeline register. It arbitrates the following sources into one consistent bubble/hold pattern:
- instruction-memory wait
- load-use hazard
- taken branch
- multicycle EX operation
- data-memory wait
- trap flush

It holds the sequential state for multicycle-op timing and post-trap flush. Lanes 1 and 2 of each stage move in lockstep; each lane-pair output is driven identically.

Parameters:
MC_LAT, 4, total EX-hold cycles for a multicycle op (>=2)
FLUSH_LEN, 2, cycles IF is held and ID bubbled after a trap (>=1)
CNT_W, 4, counter width; must hold max(MC_LAT, FLUSH_LEN)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous, active-high reset
IMEM_WAIT  input  1  fetch not complete this cycle
LD_USE_HZD  input  1  ID source matches EX load destination
BR_TAKEN  input  1  EX resolved taken branch/jump (held while EX held)
MC_START  input  1  EX holds a multicycle op (held while EX held)
DMEM_WAIT  input  1  ME access not complete this cycle
TRAP_REQ  input  1  ME raises exception/interrupt (1-cycle pulse)
IF_STALL_D  output  1  hold PC
ID1_STALL_D, ID2_STALL_D  output  1 each  hold ID input regs
ID1_CLEAR_D, ID2_CLEAR_D  output  1 each  load bubble into ID regs
EX1_STALL_D, EX2_STALL_D, EX1_CLEAR_D, EX2_CLEAR_D  output  1 each  EX regs
ME1_STALL_D, ME2_STALL_D, ME1_CLEAR_D, ME2_CLEAR_D  output  1 each  ME regs
WB1_STALL_D, WB2_STALL_D, WB1_CLEAR_D, WB2_CLEAR_D  output  1 each  WB regs
HZD_BUSY  output  1  state != RUN

Behaviour:
- Semantics:
  - X_STALL = the register feeding stage X holds at the next edge.
  - X_CLEAR = that register loads a bubble.
  - A stage never gets STALL and CLEAR together.
- Outputs are combinational from the registered state and the current inputs. Latency is zero: a request acts at the next edge.
- State: FSM {RUN, MC_BUSY, FLUSH}, down-counter cnt[CNT_W], flag mc_done.
- Reset values: RUN, cnt=0, mc_done=0. During RST high, every output is 0.
- Output patterns, in priority order (first match wins, all unlisted outputs 0):
  - TRAP_REQ (any state): clear ID, EX, ME, WB. Next state FLUSH, cnt=FLUSH_LEN-1, mc_done=0.
  - FLUSH: stall IF, clear ID. Leave to RUN when cnt==0, otherwise cnt--. DMEM_WAIT, BR_TAKEN, MC_START and LD_USE_HZD are ignored.
  - DMEM_WAIT: stall IF, ID, EX, ME; clear WB.
  - MC_BUSY, or RUN with MC_START && !mc_done: stall IF, ID, EX; clear ME.
  - BR_TAKEN: clear ID, EX. This overrides LD_USE_HZD and IMEM_WAIT.
  - LD_USE_HZD: stall IF, ID; clear EX.
  - IMEM_WAIT: stall IF; clear ID.
- Multicycle op:
  - In RUN, MC_START && !mc_done && !TRAP_REQ: go to MC_BUSY, cnt=MC_LAT-2. The start cycle is counted as hold cycle 1.
  - In MC_BUSY: cnt-- each cycle. The counter keeps counting even while DMEM_WAIT also holds the pipe.
  - When cnt==0 in MC_BUSY: go to RUN, set mc_done=1. EX is held for exactly MC_LAT cycles unless DMEM_WAIT extends it.
  - mc_done clears on any cycle where EX1_STALL_D=0 in RUN. This prevents a still-asserted MC_START from re-triggering.
- Simultaneous events:
  - Trap during MC_BUSY aborts the op.
  - Trap during FLUSH reloads cnt.
  - BR_TAKEN under DMEM_WAIT or MC hold is not acted on; EX re-presents it after release.
- Reset mid-operation: the next cycle is in RUN with all outputs 0, regardless of prior state.

Test Plan:
- Idle, all inputs 0 for 10 cycles -> all outputs 0, HZD_BUSY=0.
- LD_USE_HZD=1 for 1 cycle -> IF/ID1/ID2_STALL=1 and EX1/EX2_CLEAR=1 that cycle only. With BR_TAKEN=1 in the same cycle -> ID/EX CLEAR only, no stalls.
- MC_LAT=4: MC_START held 1 from cycle 0 until EX advances -> IF/ID/EX STALL and ME CLEAR in cycles 0-3, all outputs 0 in cycle 4, no re-trigger. A second op with MC_START high again after an EX advance stalls again for 4 cycles.
- MC op started at cycle 0 with DMEM_WAIT=1 in cycles 2-5 -> ME STALL and WB CLEAR in 2-5; EX stalled through 5; outputs 0 at cycle 6; HZD_BUSY=0 from cycle 4.
- TRAP_REQ pulse at cycle 1 during MC_BUSY (FLUSH_LEN=2) -> cycle 1 clears ID/EX/ME/WB; cycles 2-3 IF_STALL + ID CLEAR with DMEM_WAIT=1 ignored; RUN at cycle 4.
- RST asserted in cycle 2 of FLUSH -> outputs 0 while RST is high; after release, RUN with IMEM_WAIT=1 -> IF_STALL + ID CLEAR only.
